// File: rtl/cva6_cfg_reporter.sv
// Read-only configuration reporter for the CVA6 core.
// Exposes build-time configuration as a 16-word table through two paths:
//   - req/gnt/rvalid read port: req_i, addr_i, gnt_o (combinational),
//     rvalid_o, rdata_o, rerr_o, rready_i
//   - stream dump port: dump_i starts a 17-beat dump on st_valid_o/st_data_o/
//     st_last_o/st_ready_i; the final beat carries the XOR checksum.
// busy_o flags any activity (non-IDLE state or a pending dump).
// Clock clk_i, asynchronous active-high reset rst_i.
module cva6_cfg_reporter #(
  parameter int unsigned XLEN              = 32,
  parameter int unsigned FEATURES          = 32'h000000C1,
  parameter int unsigned ICACHE_SET_ASSOC  = 4,
  parameter int unsigned ICACHE_LINES      = 4096,
  parameter int unsigned ICACHE_LINE_WIDTH = 128,
  parameter int unsigned DCACHE_SET_ASSOC  = 8,
  parameter int unsigned DCACHE_LINES      = 4096,
  parameter int unsigned DCACHE_LINE_WIDTH = 128,
  parameter int unsigned NR_COMMIT_PORTS   = 2,
  parameter int unsigned NR_SB_ENTRIES     = 8,
  parameter int unsigned ITLB_ENTRIES      = 16,
  parameter int unsigned DTLB_ENTRIES      = 16,
  parameter int unsigned RAS_DEPTH         = 2,
  parameter int unsigned BTB_ENTRIES       = 32,
  parameter int unsigned BHT_ENTRIES       = 128,
  parameter int unsigned NR_PMP_ENTRIES    = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic [7:0]  addr_i,
  output logic        gnt_o,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        rerr_o,
  input  logic        rready_i,
  input  logic        dump_i,
  output logic        st_valid_o,
  output logic [31:0] st_data_o,
  output logic        st_last_o,
  input  logic        st_ready_i,
  output logic        busy_o
);

  localparam int unsigned CNT_W  = 5;
  localparam int unsigned DATA_W = 32;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RESP = 2'd1;
  localparam logic [1:0] DUMP = 2'd2;

  // Configuration word lookup
  function automatic logic [DATA_W-1:0] cfg_word(input logic [3:0] idx);
    logic [DATA_W-1:0] w;
    case (idx)
      4'd0:    w = 32'hC7A60000 | DATA_W'(XLEN);
      4'd1:    w = DATA_W'(FEATURES);
      4'd2:    w = DATA_W'(ICACHE_SET_ASSOC);
      4'd3:    w = DATA_W'(ICACHE_LINES);
      4'd4:    w = DATA_W'(ICACHE_LINE_WIDTH);
      4'd5:    w = DATA_W'(DCACHE_SET_ASSOC);
      4'd6:    w = DATA_W'(DCACHE_LINES);
      4'd7:    w = DATA_W'(DCACHE_LINE_WIDTH);
      4'd8:    w = DATA_W'(NR_COMMIT_PORTS);
      4'd9:    w = DATA_W'(NR_SB_ENTRIES);
      4'd10:   w = DATA_W'(ITLB_ENTRIES);
      4'd11:   w = DATA_W'(DTLB_ENTRIES);
      4'd12:   w = DATA_W'(RAS_DEPTH);
      4'd13:   w = DATA_W'(BTB_ENTRIES);
      4'd14:   w = DATA_W'(BHT_ENTRIES);
      default: w = DATA_W'(NR_PMP_ENTRIES);
    endcase
    return w;
  endfunction

  logic [1:0]        state, state_n;
  logic              dump_pend, dump_pend_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [DATA_W-1:0] acc, acc_n;
  logic              rvalid_n, rerr_n, st_valid_n, st_last_n, busy_n;
  logic [DATA_W-1:0] rdata_n, st_data_n;

  assign gnt_o = req_i && (state == IDLE) && !dump_pend;

  // State and registered outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= IDLE;
      dump_pend  <= 1'b0;
      cnt        <= '0;
      acc        <= '0;
      rvalid_o   <= 1'b0;
      rdata_o    <= '0;
      rerr_o     <= 1'b0;
      st_valid_o <= 1'b0;
      st_data_o  <= '0;
      st_last_o  <= 1'b0;
      busy_o     <= 1'b0;
    end else begin
      state      <= state_n;
      dump_pend  <= dump_pend_n;
      cnt        <= cnt_n;
      acc        <= acc_n;
      rvalid_o   <= rvalid_n;
      rdata_o    <= rdata_n;
      rerr_o     <= rerr_n;
      st_valid_o <= st_valid_n;
      st_data_o  <= st_data_n;
      st_last_o  <= st_last_n;
      busy_o     <= busy_n;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_n     = state;
    dump_pend_n = dump_pend;
    cnt_n       = cnt;
    acc_n       = acc;
    rvalid_n    = rvalid_o;
    rdata_n     = rdata_o;
    rerr_n      = rerr_o;
    st_valid_n  = st_valid_o;
    st_data_n   = st_data_o;
    st_last_n   = st_last_o;

    case (state)
      IDLE: begin
        if (gnt_o) begin
          state_n     = RESP;
          rvalid_n    = 1'b1;
          dump_pend_n = dump_i;
          if (addr_i < 8'd16) begin
            rdata_n = cfg_word(addr_i[3:0]);
            rerr_n  = 1'b0;
          end else begin
            rdata_n = '0;
            rerr_n  = 1'b1;
          end
        end else if (dump_i || dump_pend) begin
          state_n     = DUMP;
          dump_pend_n = 1'b0;
          cnt_n       = '0;
          acc_n       = '0;
          st_valid_n  = 1'b1;
          st_data_n   = cfg_word(4'd0);
          st_last_n   = 1'b0;
        end
      end
      RESP: begin
        if (dump_i) dump_pend_n = 1'b1;
        if (rready_i) begin
          rvalid_n = 1'b0;
          rdata_n  = '0;
          rerr_n   = 1'b0;
          // A dump requested during or before this response starts right away
          if (dump_pend || dump_i) begin
            state_n     = DUMP;
            dump_pend_n = 1'b0;
            cnt_n       = '0;
            acc_n       = '0;
            st_valid_n  = 1'b1;
            st_data_n   = cfg_word(4'd0);
            st_last_n   = 1'b0;
          end else begin
            state_n = IDLE;
          end
        end
      end
      DUMP: begin
        if (st_ready_i) begin
          acc_n = acc ^ st_data_o;
          if (cnt == CNT_W'(16)) begin
            state_n    = IDLE;
            cnt_n      = '0;
            st_valid_n = 1'b0;
            st_data_n  = '0;
            st_last_n  = 1'b0;
          end else begin
            cnt_n = cnt + CNT_W'(1);
            // After beat 15 the next beat is the running checksum
            if (cnt == CNT_W'(15)) begin
              st_data_n = acc ^ st_data_o;
              st_last_n = 1'b1;
            end else begin
              st_data_n = cfg_word(cnt_n[3:0]);
              st_last_n = 1'b0;
            end
          end
        end
      end
      default: state_n = IDLE;
    endcase

    busy_n = (state_n != IDLE) || dump_pend_n;
  end

endmodule

// File: tb/tb_cva6_cfg_reporter.sv
// Directed, table-driven bench for cva6_cfg_reporter: read-port vectors plus
// hand-written dump, collision and reset-abort sequences.
module tb_cva6_cfg_reporter;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        req_i = 1'b0;
  logic [7:0]  addr_i = 8'd0;
  logic        gnt_o;
  logic        rvalid_o;
  logic [31:0] rdata_o;
  logic        rerr_o;
  logic        rready_i = 1'b0;
  logic        dump_i = 1'b0;
  logic        st_valid_o;
  logic [31:0] st_data_o;
  logic        st_last_o;
  logic        st_ready_i = 1'b0;
  logic        busy_o;

  int tests = 0;
  int fails = 0;

  cva6_cfg_reporter dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .addr_i(addr_i),
    .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o), .rerr_o(rerr_o),
    .rready_i(rready_i), .dump_i(dump_i), .st_valid_o(st_valid_o),
    .st_data_o(st_data_o), .st_last_o(st_last_o), .st_ready_i(st_ready_i),
    .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [7:0]  addr;
    int          stall;
    logic [31:0] data;
    logic        err;
  } vec_t;

  vec_t        vecs[7];
  logic [31:0] exp_words[17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One read transaction starting at a negedge; ends at a negedge
  task automatic do_read(input vec_t v);
    req_i = 1'b1; addr_i = v.addr;
    #1 chk("gnt", 32'(gnt_o), 32'd1);
    @(negedge clk_i);
    req_i = 1'b0;
    chk("rvalid", 32'(rvalid_o), 32'd1);
    chk("rdata", rdata_o, v.data);
    chk("rerr", 32'(rerr_o), 32'(v.err));
    for (int i = 0; i < v.stall; i++) begin
      req_i = 1'b1;
      #1 chk("gnt_stall", 32'(gnt_o), 32'd0);
      chk("rdata_stall", rdata_o, v.data);
      chk("rvalid_stall", 32'(rvalid_o), 32'd1);
      @(negedge clk_i);
    end
    req_i = 1'b0; rready_i = 1'b1;
    @(negedge clk_i);
    rready_i = 1'b0;
    chk("rvalid_drop", 32'(rvalid_o), 32'd0);
  endtask

  // Collect dump beats starting at a negedge; optional reset abort and re-pulse
  task automatic collect(input bit rnd, input int abort_at, input int pulse_at);
    int    beat = 0;
    bit    pulsed = 1'b0;
    bit    pv = 1'b0, pr = 1'b0, pl = 1'b0;
    logic [31:0] pd = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (beat == abort_at) begin
        st_ready_i = 1'b0;
        rst_i = 1'b1;
        return;
      end
      st_ready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      dump_i = (beat == pulse_at) && !pulsed;
      if (dump_i) pulsed = 1'b1;
      #1;
      if (pv && !pr) begin
        chk("st_hold_valid", 32'(st_valid_o), 32'd1);
        chk("st_hold_data", st_data_o, pd);
        chk("st_hold_last", 32'(st_last_o), 32'(pl));
      end
      pv = st_valid_o; pr = st_ready_i; pd = st_data_o; pl = st_last_o;
      if (st_valid_o && st_ready_i) begin
        chk($sformatf("beat%0d_data", beat), st_data_o, exp_words[beat]);
        chk($sformatf("beat%0d_last", beat), 32'(st_last_o), 32'(beat == 16));
        beat++;
      end
      @(negedge clk_i);
      dump_i = 1'b0;
      if (beat == 17) begin
        st_ready_i = 1'b0;
        chk("st_valid_end", 32'(st_valid_o), 32'd0);
        chk("busy_end", 32'(busy_o), 32'd0);
        return;
      end
    end
    chk("dump_timeout", 32'(beat), 32'd17);
    st_ready_i = 1'b0;
  endtask

  initial begin
    logic [31:0] x;
    exp_words[0]  = 32'hC7A60020; exp_words[1]  = 32'h000000C1;
    exp_words[2]  = 32'd4;        exp_words[3]  = 32'd4096;
    exp_words[4]  = 32'd128;      exp_words[5]  = 32'd8;
    exp_words[6]  = 32'd4096;     exp_words[7]  = 32'd128;
    exp_words[8]  = 32'd2;        exp_words[9]  = 32'd8;
    exp_words[10] = 32'd16;       exp_words[11] = 32'd16;
    exp_words[12] = 32'd2;        exp_words[13] = 32'd32;
    exp_words[14] = 32'd128;      exp_words[15] = 32'd8;
    x = '0;
    for (int i = 0; i < 16; i++) x = x ^ exp_words[i];
    exp_words[16] = x;

    vecs[0] = '{addr: 8'd0,   stall: 0, data: 32'hC7A60020, err: 1'b0};
    vecs[1] = '{addr: 8'd3,   stall: 4, data: 32'd4096,     err: 1'b0};
    vecs[2] = '{addr: 8'd1,   stall: 0, data: 32'h000000C1, err: 1'b0};
    vecs[3] = '{addr: 8'd16,  stall: 1, data: 32'd0,        err: 1'b1};
    vecs[4] = '{addr: 8'd255, stall: 0, data: 32'd0,        err: 1'b1};
    vecs[5] = '{addr: 8'd15,  stall: 2, data: 32'd8,        err: 1'b0};
    vecs[6] = '{addr: 8'd10,  stall: 0, data: 32'd16,       err: 1'b0};

    // Reset state
    #12;
    chk("rst_rvalid", 32'(rvalid_o), 32'd0);
    chk("rst_rdata", rdata_o, 32'd0);
    chk("rst_st_valid", 32'(st_valid_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);

    // Read port vectors
    for (int i = 0; i < 7; i++) do_read(vecs[i]);

    // Plain dump with always-ready sink
    dump_i = 1'b1;
    @(negedge clk_i);
    dump_i = 1'b0;
    chk("dump_busy", 32'(busy_o), 32'd1);
    collect(1'b0, -1, -1);

    // Request and dump in the same cycle: response first, then dump
    req_i = 1'b1; addr_i = 8'd13; dump_i = 1'b1;
    #1 chk("coll_gnt", 32'(gnt_o), 32'd1);
    @(negedge clk_i);
    req_i = 1'b0; dump_i = 1'b0;
    chk("coll_rvalid", 32'(rvalid_o), 32'd1);
    chk("coll_rdata", rdata_o, 32'd32);
    chk("coll_busy", 32'(busy_o), 32'd1);
    @(negedge clk_i);
    chk("coll_no_stream", 32'(st_valid_o), 32'd0);
    rready_i = 1'b1;
    @(negedge clk_i);
    rready_i = 1'b0;
    chk("coll_rvalid_drop", 32'(rvalid_o), 32'd0);
    chk("coll_dump_start", 32'(st_valid_o), 32'd1);
    collect(1'b0, -1, 5);
    for (int i = 0; i < 4; i++) begin
      chk("no_restart", 32'(st_valid_o), 32'd0);
      @(negedge clk_i);
    end

    // Random backpressure, reset at beat 7
    dump_i = 1'b1;
    @(negedge clk_i);
    dump_i = 1'b0;
    collect(1'b1, 7, -1);
    #1;
    chk("abort_st_valid", 32'(st_valid_o), 32'd0);
    chk("abort_st_data", st_data_o, 32'd0);
    chk("abort_st_last", 32'(st_last_o), 32'd0);
    chk("abort_rvalid", 32'(rvalid_o), 32'd0);
    chk("abort_busy", 32'(busy_o), 32'd0);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    chk("post_rst_idle", 32'(st_valid_o), 32'd0);
    dump_i = 1'b1;
    @(negedge clk_i);
    dump_i = 1'b0;
    collect(1'b1, -1, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
